// File: rtl/snn_cfg_pkg.sv
// snn_cfg_pkg: shared constants, header layout and FSM encoding for the SNN parameter loader.
package snn_cfg_pkg;
   localparam int DEPTH = 125;
   localparam int AW = 7;
   localparam int DW = 8;
   localparam int HDR_RD_BIT = 7;
   localparam int HDR_ADDR_MSB = 6;
   localparam int HDR_ADDR_LSB = 0;
   // Parameter memory regions: weights, then neuron thresholds, then config bytes.
   localparam logic [AW-1:0] WEIGHT_BASE = 7'd0;
   localparam logic [AW-1:0] THRESH_BASE = 7'd100;
   localparam logic [AW-1:0] CONFIG_BASE = 7'd116;
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DISCARD, S_DONE} state_t;
endpackage

// File: rtl/snn_cfg_loader.sv
// snn_cfg_loader: turns framed byte bursts into bounds-checked, auto-incrementing writes to the parameter memory.
module snn_cfg_loader #(
   parameter int DEPTH = snn_cfg_pkg::DEPTH,
   parameter int AW = snn_cfg_pkg::AW,
   parameter int DW = snn_cfg_pkg::DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          abort,
   input  logic [DW-1:0] rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic [DW-1:0] mem_data_in,
   output logic [AW-1:0] mem_addr,
   output logic          mem_write_enable,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          loaded
);
   import snn_cfg_pkg::*;
   state_t state, state_nx;
   logic [AW-1:0] start, addr;
   logic [7:0] remaining;
   logic [8:0] frame_end;
   logic acc, bad_len;
   assign rx_ready = !reset && !abort && state != S_DONE;
   assign acc = rx_valid && rx_ready;
   assign busy = state != S_IDLE;
   assign done = state == S_DONE;
   // Nine bits so S + 255 cannot overflow before the bounds compare.
   assign frame_end = 9'(start) + 9'(rx_data);
   assign bad_len = frame_end > 9'(DEPTH) || 9'(start) >= 9'(DEPTH);
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    state_nx = acc && !rx_data[HDR_RD_BIT] ? S_LEN : S_IDLE;
         S_LEN:     if (acc) state_nx = rx_data == '0 ? S_DONE : bad_len ? S_DISCARD : S_DATA;
         S_DATA:    if (acc && remaining == 8'd1) state_nx = S_DONE;
         S_DISCARD: if (acc && remaining == 8'd1) state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
      if (abort) state_nx = S_IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         start <= '0;
         addr <= '0;
         remaining <= '0;
         mem_addr <= '0;
         mem_data_in <= '0;
         mem_write_enable <= 1'b0;
         err <= 1'b0;
         loaded <= 1'b0;
      end else begin
         state <= state_nx;
         mem_write_enable <= acc && state == S_DATA;
         if (state == S_DONE) loaded <= 1'b1;
         if (acc) begin
            case (state)
               S_IDLE: begin
                  err <= rx_data[HDR_RD_BIT];
                  if (!rx_data[HDR_RD_BIT]) start <= rx_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
               end
               S_LEN: begin
                  remaining <= rx_data;
                  addr <= start;
                  if (rx_data != '0 && bad_len) err <= 1'b1;
               end
               S_DATA: begin
                  mem_addr <= addr;
                  mem_data_in <= rx_data;
                  addr <= addr + 1'b1;
                  remaining <= remaining - 8'd1;
               end
               S_DISCARD: remaining <= remaining - 8'd1;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_snn_cfg_loader.sv
// tb_snn_cfg_loader: directed frames; expected writes go to a queue that a negedge monitor checks.
module tb_snn_cfg_loader;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic abort = 1'b0;
   logic [7:0] rx_data = '0;
   logic rx_valid = 1'b0;
   logic rx_ready, mem_write_enable, busy, done, err, loaded;
   logic [7:0] mem_data_in;
   logic [6:0] mem_addr;
   logic [14:0] exp_q[$];
   logic [7:0] pl[$];
   int checks = 0, errors = 0;
   int done_cnt = 0, ready_low = 0, run = 0, max_run = 0;

   snn_cfg_loader dut (
      .clk(clk), .reset(reset), .abort(abort), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .mem_data_in(mem_data_in), .mem_addr(mem_addr),
      .mem_write_enable(mem_write_enable), .busy(busy), .done(done), .err(err), .loaded(loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_write_enable) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write: unexpected write addr %0d data 0x%0h", mem_addr, mem_data_in);
         end else begin
            logic [14:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_data_in} != e) begin
               errors++;
               $display("FAIL write: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                        mem_addr, mem_data_in, e[14:8], e[7:0]);
            end
         end
      end
      if (done) done_cnt++;
      if (!rx_ready && !reset) ready_low++;
      run = mem_write_enable ? run + 1 : 0;
      if (run > max_run) max_run = run;
   end

   task automatic send(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = b;
      while (!rx_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) begin
         errors++;
         $display("FAIL send: rx_ready stuck low for byte 0x%0h", b);
      end
      @(posedge clk);
   endtask

   task automatic settle();
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] h, input logic [7:0] l);
      if (!h[7] && l != 0 && 9'(h[6:0]) + 9'(l) <= 9'd125)
         for (int i = 0; i < int'(l); i++) exp_q.push_back({7'(h[6:0] + 7'(i)), pl[i]});
      send(h);
      if (!h[7]) begin
         send(l);
         for (int i = 0; i < int'(l); i++) send(pl[i]);
      end
      settle();
   endtask

   initial begin
      int d0;
      #1 reset = 1'b1;
      #2;
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_we", mem_write_enable, 0);
      chk("rst_busy", busy, 0);
      chk("rst_loaded", loaded, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", mem_addr, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 chk("idle_rx_ready", rx_ready, 1);

      d0 = done_cnt; max_run = 0;
      pl = '{8'hAA, 8'hBB, 8'hCC};
      frame(8'h05, 8'd3);
      chk("t1_done", done_cnt - d0, 1);
      chk("t1_backtoback", max_run, 3);
      chk("t1_loaded", loaded, 1);
      chk("t1_err", err, 0);
      chk("t1_busy", busy, 0);

      d0 = done_cnt;
      pl = '{8'h01, 8'h02, 8'h03};
      frame(8'h7A, 8'd3);
      chk("t2_top_done", done_cnt - d0, 1);
      chk("t2_top_err", err, 0);

      d0 = done_cnt;
      pl = '{8'h04, 8'h05, 8'h06};
      frame(8'h7B, 8'd3);
      chk("t2_ovf_done", done_cnt - d0, 0);
      chk("t2_ovf_err", err, 1);
      chk("t2_ovf_busy", busy, 0);

      d0 = done_cnt; ready_low = 0;
      frame(8'h10, 8'd0);
      chk("t4_l0_done", done_cnt - d0, 1);
      chk("t4_l0_ready_low", ready_low, 1);
      chk("t4_l0_err", err, 0);

      frame(8'h80, 8'd0);
      chk("t3_rd_err", err, 1);
      chk("t3_rd_busy", busy, 0);
      d0 = done_cnt;
      pl = '{8'h11};
      frame(8'h00, 8'd1);
      chk("t3_err_clear", err, 0);
      chk("t3_done", done_cnt - d0, 1);

      d0 = done_cnt;
      exp_q.push_back({7'h20, 8'h51});
      exp_q.push_back({7'h21, 8'h52});
      send(8'h20);
      send(8'd4);
      send(8'h51);
      send(8'h52);
      @(negedge clk);
      abort = 1'b1;
      rx_data = 8'h53;
      #1 chk("ab_ready_low", rx_ready, 0);
      @(negedge clk);
      abort = 1'b0;
      rx_valid = 1'b0;
      #1 chk("ab_busy", busy, 0);
      settle();
      chk("ab_done", done_cnt - d0, 0);
      chk("ab_err", err, 0);
      chk("ab_loaded", loaded, 1);
      chk("ab_q_empty", exp_q.size(), 0);
      d0 = done_cnt;
      pl = '{8'h61, 8'h62};
      frame(8'h40, 8'd2);
      chk("ab_next_done", done_cnt - d0, 1);

      exp_q.push_back({7'h30, 8'h71});
      send(8'h30);
      send(8'd4);
      send(8'h71);
      send(8'h72);
      #3 reset = 1'b1;
      rx_valid = 1'b0;
      #1;
      chk("mr_rx_ready", rx_ready, 0);
      chk("mr_we", mem_write_enable, 0);
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_loaded", loaded, 0);
      chk("mr_addr", mem_addr, 0);
      chk("mr_data", mem_data_in, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      d0 = done_cnt;
      pl = '{8'h81, 8'h82};
      frame(8'h7B, 8'd2);
      chk("mr_next_done", done_cnt - d0, 1);
      chk("mr_next_loaded", loaded, 1);
      chk("final_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
